// File: rtl/cam_axis_bridge.sv
// Camera pixel stream to AXI4-Stream bridge: frame-aligned capture into a
// first-word-fall-through FIFO with overflow tracking and frame statistics.
module cam_axis_bridge #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [$clog2(IMG_WIDTH)-1:0]  hcount,
   input  logic [$clog2(IMG_HEIGHT)-1:0] vcount,
   input  logic [DATA_WIDTH-1:0]         din,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tuser,
   output logic                          m_axis_tlast,
   output logic                          overflow,
   input  logic                          clr_overflow,
   output logic [15:0]                   frame_count,
   output logic [15:0]                   drop_count,
   output logic [1:0]                    state_o
);

   localparam int HW = $clog2(IMG_WIDTH);
   localparam int VW = $clog2(IMG_HEIGHT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_WIDTH + 2;

   // Debug encoding on state_o: 0 = WAIT_SOF, 1 = PASS, 2 = DROP.
   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      PASS     = 2'd1,
      DROP     = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW:0]     wr_q, wr_d;
   logic [AW:0]     rd_q, rd_d;
   logic            ovf_q, ovf_d;
   logic [15:0]     frame_q, frame_d;
   logic [15:0]     drop_q, drop_d;
   logic [EW-1:0]   mem_q [FIFO_DEPTH];

   logic [AW:0]     level;
   logic            full, empty;
   logic            sof, eol, last_line;
   logic            push, pop, lose;
   logic [EW-1:0]   head;

   // AXI-Stream handshake: a beat transfers on a rising edge where tvalid and
   // tready are both high; while tvalid=1 and tready=0 the head entry is held.
   assign level     = wr_q - rd_q;
   assign full      = (level == (AW+1)'(FIFO_DEPTH));
   assign empty     = (wr_q == rd_q);
   assign sof       = (hcount == '0) && (vcount == '0);
   assign eol       = (hcount == HW'(IMG_WIDTH - 1));
   assign last_line = (vcount == VW'(IMG_HEIGHT - 1));
   assign pop       = !empty && m_axis_tready;
   assign head      = mem_q[rd_q[AW-1:0]];

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      lose    = 1'b0;
      case (state_q)
         PASS: begin
            if (in_valid) begin
               if (!full) begin
                  push = 1'b1;
               end else begin
                  lose    = 1'b1;
                  state_d = DROP;
               end
            end
         end
         default: begin
            // WAIT_SOF and DROP only re-synchronise on a start-of-frame pixel.
            if (in_valid && sof) begin
               if (!full) begin
                  push    = 1'b1;
                  state_d = PASS;
               end else begin
                  lose = 1'b1;
               end
            end
         end
      endcase
   end

   always_comb begin
      wr_d    = push ? wr_q + 1'b1 : wr_q;
      rd_d    = pop ? rd_q + 1'b1 : rd_q;
      frame_d = (push && eol && last_line) ? frame_q + 16'd1 : frame_q;
      drop_d  = lose ? drop_q + 16'd1 : drop_q;
      ovf_d   = ovf_q;
      if (lose) begin
         ovf_d = 1'b1;
      end else if (clr_overflow) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WAIT_SOF;
         wr_q    <= '0;
         rd_q    <= '0;
         ovf_q   <= 1'b0;
         frame_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         ovf_q   <= ovf_d;
         frame_q <= frame_d;
         drop_q  <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q[AW-1:0]] <= {sof, eol, din};
      end
   end

   // Outputs are gated by empty so stale storage never leaks after reset.
   assign m_axis_tvalid = !empty;
   assign m_axis_tuser  = !empty && head[EW-1];
   assign m_axis_tlast  = !empty && head[EW-2];
   assign m_axis_tdata  = empty ? '0 : head[DATA_WIDTH-1:0];
   assign overflow      = ovf_q;
   assign frame_count   = frame_q;
   assign drop_count    = drop_q;
   assign state_o       = state_q;

endmodule

// File: doc/cam_axis_bridge.md
CAM_AXIS_BRIDGE -- requirements
Module: cam_axis_bridge

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines per frame.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, entries; a power of 2 and at least 4.
REQ-005 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port: rst  input  1  reset, asynchronous assert, active-high.
REQ-007 SHALL have port: in_valid  input  1  pixel present this cycle.
REQ-008 SHALL have port: hcount  input  $clog2(IMG_WIDTH)  column of current pixel.
REQ-009 SHALL have port: vcount  input  $clog2(IMG_HEIGHT)  line of current pixel.
REQ-010 SHALL have port: din  input  DATA_WIDTH  pixel value.
REQ-011 SHALL have port: m_axis_tdata  output  DATA_WIDTH  stream pixel.
REQ-012 SHALL have port: m_axis_tvalid  output  1  stream valid.
REQ-013 SHALL have port: m_axis_tready  input  1  stream ready.
REQ-014 SHALL have port: m_axis_tuser  output  1  start of frame (pixel 0,0).
REQ-015 SHALL have port: m_axis_tlast  output  1  last pixel of line.
REQ-016 SHALL have port: overflow  output  1  sticky pixel-lost flag.
REQ-017 SHALL have port: clr_overflow  input  1  clears overflow.
REQ-018 SHALL have port: frame_count  output  16  complete frames accepted.
REQ-019 SHALL have port: drop_count  output  16  frames aborted by overflow.

Function
REQ-020 SHALL store tuples {sof, eol, din} in a FIFO of FIFO_DEPTH entries, where sof = (hcount==0 && vcount==0) and eol = (hcount==IMG_WIDTH-1).
REQ-021 SHALL present the FIFO head as first-word-fall-through: m_axis_tvalid = not empty; tdata/tuser/tlast from the head entry.
REQ-022 SHALL pop exactly when m_axis_tvalid && m_axis_tready.
REQ-023 SHALL hold tdata/tuser/tlast stable while tvalid=1 and tready=0.
REQ-024 SHALL implement state machine WAIT_SOF, PASS, DROP.
- Reset state: WAIT_SOF.
REQ-025 In WAIT_SOF, SHALL discard every input pixel.
- Transition to PASS, pushing the pixel, on in_valid && sof && not full.
- On in_valid && sof && full: stay in WAIT_SOF, set overflow, increment drop_count.
REQ-026 In PASS, SHALL push every in_valid pixel while not full.
- On in_valid && full: discard the pixel, set overflow, increment drop_count, go to DROP.
REQ-027 In PASS, an in_valid && sof pixel SHALL be pushed normally; a new frame restarts without leaving PASS.
REQ-028 In DROP, SHALL discard all pixels until in_valid && sof.
- That pixel is then handled exactly as in WAIT_SOF.
REQ-029 "full" SHALL be evaluated on the registered level before the same-cycle pop.
- A push while full is rejected even when a pop occurs in that cycle.
REQ-030 Simultaneous push and pop when not full and not empty SHALL leave the level unchanged.
REQ-031 Latency: a pixel pushed in cycle N into an empty FIFO SHALL appear on m_axis with tvalid=1 in cycle N+1.
REQ-032 frame_count SHALL increment when the pixel with hcount=IMG_WIDTH-1 and vcount=IMG_HEIGHT-1 is pushed in PASS.
REQ-033 frame_count and drop_count SHALL be 16-bit and wrap from 16'hFFFF to 0.
REQ-034 overflow SHALL be set by any discarded pixel in PASS or at SOF, and cleared by clr_overflow.
- Set wins over clear in the same cycle.
REQ-035 In_valid=0 cycles SHALL cause no state, FIFO or counter change.

Reset
REQ-036 rst=1 SHALL asynchronously:
- empty the FIFO;
- force m_axis_tvalid=0, tuser=0, tlast=0, tdata=0;
- force overflow=0, frame_count=0, drop_count=0;
- force state WAIT_SOF.
REQ-037 Reset mid-frame SHALL discard buffered pixels; after release, output resumes only from the next SOF pixel.

Verification
(IMG_WIDTH=4, IMG_HEIGHT=2, FIFO_DEPTH=4, unless noted)
REQ-038 Free flow:
- Stimulus: tready=1; two frames of continuous in_valid with din=hcount+4*vcount.
- Response: 16 beats, data 0..7 twice; tuser on beats 0 and 8; tlast on beats 3,7,11,15; frame_count=2; overflow=0.
REQ-039 Mid-frame start:
- Stimulus: feed begins at hcount=2, vcount=1.
- Response: no output until the next (0,0); first output beat has tuser=1.
REQ-040 Backpressure:
- Stimulus: tready=0 from frame start.
- Response: 4 pixels buffered; 5th pixel lost; overflow=1; drop_count=1; state DROP.
- Then tready=1: exactly data 0,1,2,3 are emitted.
- Next frame: passes complete; frame_count increments.
REQ-041 Full with same-cycle pop:
- Stimulus: FIFO full; tready=1 and in_valid=1 in the same cycle.
- Response: push rejected; overflow=1; level goes 4->3.
REQ-042 Stall stability:
- Stimulus: tready toggles 0/1 each cycle.
- Response: tdata/tuser/tlast never change while tvalid=1 and tready=0; no data lost or duplicated.
REQ-043 Async reset:
- Stimulus: rst pulsed between clock edges with FIFO at level 3.
- Response: tvalid=0 before the next clk edge; counters=0; output resumes at the next SOF.
